lfsr_prng_gen: RTL

- Parametrised Galois LFSR pseudo-random number generator for the guessing-game datapath. Successor to the fixed 8-bit LFSRprng.
- Generalises register width, tap polynomial and output word width.
- Adds a valid/ready output handshake, zero-seed lockup protection and an optional period monitor.
- Generates one bit per clock and presents a full OUT_W-bit word to the consumer (BCD display or compare logic).

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/lfsr_galois_step.sv | 19 +
 rtl/lfsr_prng_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the Galois LFSR pseudo-random generator.
//   lfsr_state_e     : word-assembly FSM states
//   TAPS_8/16/32     : known maximal-length Galois feedback masks
//   SEED_DEFAULT_VAL : reset / lockup-replacement seed (zero-extended)
//   default_taps()   : picks a maximal-length mask for a supported width
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    VALID = 2'd2
  } lfsr_state_e;

  localparam logic [7:0]  TAPS_8           = 8'hB8;
  localparam logic [15:0] TAPS_16          = 16'hB400;
  localparam logic [31:0] TAPS_32          = 32'h80200003;
  localparam logic [63:0] SEED_DEFAULT_VAL = 64'd1;

  // Widths other than 8/16/32 must override TAPS explicitly.
  function automatic logic [63:0] default_taps(input int unsigned width);
    logic [63:0] t;
    case (width)
      8:       t = 64'(TAPS_8);
      16:      t = 64'(TAPS_16);
      default: t = 64'(TAPS_32);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_galois_step.sv
// One combinational step of a right-shifting Galois LFSR.
//   i_state     : current LFSR state
//   o_next_c    : state after one shift
//   o_out_bit_c : bit shifted out this step (LSB of i_state)
module lfsr_galois_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_32)
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next_c,
  output logic             o_out_bit_c
);

  assign o_out_bit_c = i_state[0];
  assign o_next_c    = (i_state >> 1) ^ (i_state[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_prng_gen.sv
// Parametrised Galois LFSR PRNG: one bit per clock, OUT_W-bit words presented
// with a valid/ready handshake; zero seeds are replaced by SEED_DEFAULT.
// Optional period monitor enabled by defining LFSR_PERIOD_CHECK_EN.
//   clk, reset_n            : clock, async active-low reset
//   enable                  : run/pause generation
//   load, seed              : synchronous seed load (priority over all but reset)
//   prn, prn_valid, prn_ready : output word handshake
//   zero_seed               : pulse when an all-zero seed was replaced
//   step_count, period_wrap : period monitor (tied to 0 when disabled)
module lfsr_prng_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      OUT_W        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(SEED_DEFAULT_VAL)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [OUT_W-1:0] prn,
  output logic             prn_valid,
  input  logic             prn_ready,
  output logic             zero_seed,
  output logic [WIDTH-1:0] step_count,
  output logic             period_wrap
);

  localparam int unsigned      CNT_W    = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);

  lfsr_state_e      r_state,   w_state_nxt;
  logic [WIDTH-1:0] r_lfsr,    w_lfsr_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [OUT_W-1:0] r_word,    w_word_nxt;
  logic [OUT_W-1:0] r_prn,     w_prn_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_zero,    w_zero_nxt;

  logic [WIDTH-1:0] w_step_nxt;
  logic [WIDTH-1:0] w_load_val;
  logic [OUT_W-1:0] w_word_done;
  logic             w_out_bit;
  logic             w_load_zero;

  lfsr_galois_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .i_state     (r_lfsr),
    .o_next_c    (w_step_nxt),
    .o_out_bit_c (w_out_bit)
  );

  // Zero seed would lock the LFSR at 0, so substitute the default.
  assign w_load_zero = (seed == '0);
  assign w_load_val  = w_load_zero ? SEED_DEFAULT : seed;
  // First generated bit ends up as the word MSB.
  assign w_word_done = {r_word[OUT_W-2:0], w_out_bit};

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_lfsr    <= SEED_DEFAULT;
      r_bit_cnt <= '0;
      r_word    <= '0;
      r_prn     <= '0;
      r_valid   <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_word    <= w_word_nxt;
      r_prn     <= w_prn_nxt;
      r_valid   <= w_valid_nxt;
      r_zero    <= w_zero_nxt;
    end
  end

  // Next-state logic: load overrides the FSM; GEN freezes while enable=0.
  always_comb begin
    w_state_nxt   = r_state;
    w_lfsr_nxt    = r_lfsr;
    w_bit_cnt_nxt = r_bit_cnt;
    w_word_nxt    = r_word;
    w_prn_nxt     = r_prn;
    w_valid_nxt   = r_valid;
    w_zero_nxt    = 1'b0;
    if (load) begin
      w_state_nxt   = IDLE;
      w_lfsr_nxt    = w_load_val;
      w_bit_cnt_nxt = '0;
      w_word_nxt    = '0;
      w_valid_nxt   = 1'b0;
      w_zero_nxt    = w_load_zero;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            w_state_nxt   = GEN;
            w_bit_cnt_nxt = '0;
          end
        end
        GEN: begin
          if (enable) begin
            w_lfsr_nxt = w_step_nxt;
            w_word_nxt = w_word_done;
            if (r_bit_cnt == LAST_BIT) begin
              w_prn_nxt     = w_word_done;
              w_valid_nxt   = 1'b1;
              w_bit_cnt_nxt = '0;
              w_state_nxt   = VALID;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
          end
        end
        VALID: begin
          if (r_valid && prn_ready) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = enable ? GEN : IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign prn       = r_prn;
  assign prn_valid = r_valid;
  assign zero_seed = r_zero;

`ifdef LFSR_PERIOD_CHECK_EN
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_step_cnt;
  logic             r_wrap;
  logic             w_shift;

  assign w_shift = (r_state == GEN) && enable && !load;

  // Counts shifts since reset/load; pulses when the start state recurs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start    <= SEED_DEFAULT;
      r_step_cnt <= '0;
      r_wrap     <= 1'b0;
    end else if (load) begin
      r_start    <= w_load_val;
      r_step_cnt <= '0;
      r_wrap     <= 1'b0;
    end else if (w_shift) begin
      if (w_step_nxt == r_start) begin
        r_step_cnt <= '0;
        r_wrap     <= 1'b1;
      end else begin
        r_step_cnt <= r_step_cnt + WIDTH'(1);
        r_wrap     <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign step_count  = r_step_cnt;
  assign period_wrap = r_wrap;
`else
  assign step_count  = '0;
  assign period_wrap = 1'b0;
`endif

endmodule
